// File: rtl/move_input_pkg.sv
// move_input_pkg: move codes, FSM state encoding and small helpers shared by
// the board-input stage and the game-logic stage.
//   move_t    : 3-bit move code driven on the game-logic move input
//   state_t   : input-stage arbitration FSM states
//   btn index : UP=0, DOWN=1, LEFT=2, RIGHT=3, RESET=4 (code = index + 1)
package move_input_pkg;

    typedef enum logic [2:0] {
        MOVE_NONE  = 3'd0,
        MOVE_UP    = 3'd1,
        MOVE_DOWN  = 3'd2,
        MOVE_LEFT  = 3'd3,
        MOVE_RIGHT = 3'd4,
        MOVE_RESET = 3'd5
    } move_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int NUM_BTN   = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_RESET = 4;

    // Fixed priority: RESET > UP > DOWN > LEFT > RIGHT.
    function automatic move_t arbitrate(input logic [NUM_BTN-1:0] ev);
        move_t m;
        m = MOVE_NONE;
        if (ev[BTN_RESET])      m = MOVE_RESET;
        else if (ev[BTN_UP])    m = MOVE_UP;
        else if (ev[BTN_DOWN])  m = MOVE_DOWN;
        else if (ev[BTN_LEFT])  m = MOVE_LEFT;
        else if (ev[BTN_RIGHT]) m = MOVE_RIGHT;
        return m;
    endfunction

    // One-hot button mask for a move code; NONE selects no button.
    function automatic logic [NUM_BTN-1:0] move_mask(input move_t m);
        logic [NUM_BTN-1:0] mask;
        case (m)
            MOVE_UP:    mask = 5'b00001;
            MOVE_DOWN:  mask = 5'b00010;
            MOVE_LEFT:  mask = 5'b00100;
            MOVE_RIGHT: mask = 5'b01000;
            MOVE_RESET: mask = 5'b10000;
            default:    mask = 5'b00000;
        endcase
        return mask;
    endfunction

    function automatic logic is_direction(input move_t m);
        return (m == MOVE_UP) || (m == MOVE_DOWN) ||
               (m == MOVE_LEFT) || (m == MOVE_RIGHT);
    endfunction

endpackage

// File: rtl/move_input_debounce.sv
// move_input_debounce: 2-flop synchroniser followed by a stable-count
// debouncer for one raw push-button.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn        : raw active-high button, asynchronous to clk
//   level      : debounced level, delayed one cycle so it lines up with pressed
//   pressed    : one-cycle pulse on a debounced rising edge
module move_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic pressed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d1_q;
    logic             pressed_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            pressed_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            // cnt_q holds how many earlier consecutive cycles the input
            // already differed; the flip happens on the DEBOUNCE_CYCLES-th.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            level_d1_q <= level_q;
            pressed_q  <= level_q & ~level_d1_q;
        end
    end

    // Presses and releases reach the FSM with the same latency.
    assign level   = level_d1_q;
    assign pressed = pressed_q;

endmodule

// File: rtl/move_input.sv
// move_input: turns five raw board buttons into single-cycle move pulses for
// the game logic, with priority arbitration and auto-repeat of held
// direction keys.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   btn_up .. btn_reset: raw active-high buttons, asynchronous to clk
//   move               : registered move code, NONE except single-cycle pulses
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no owner; next press event (by priority) emits and takes ownership
// ST_OWNED  | owner held, counting towards the first repeat
// ST_REPEAT | owner held, repeating every REPEAT_PERIOD+1 cycles
module move_input
    import move_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 15_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_reset,
    output logic [2:0] move
);

    localparam int CNT_MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W    = $clog2(CNT_MAXV + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAXV);
    localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] pressed;

    assign btn_raw = {btn_reset, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        move_input_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .btn     (btn_raw[i]),
            .level   (level[i]),
            .pressed (pressed[i])
        );
    end

    state_t           state_q, state_d;
    move_t            owner_q, owner_d;
    move_t            move_q, move_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    move_t            pick;
    logic             owner_rel;
    logic             repeat_en;
    logic             delay_hit;
    logic             period_hit;

    assign pick       = arbitrate(pressed);
    assign owner_rel  = ~|(level & move_mask(owner_q));
    assign repeat_en  = (REPEAT_DELAY != 0) && is_direction(owner_q);
    assign delay_hit  = repeat_en && (cnt_q == DELAY_C);
    assign period_hit = (cnt_q == PERIOD_C);
    assign cnt_inc    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= MOVE_NONE;
            move_q  <= MOVE_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            move_q  <= move_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pick != MOVE_NONE) state_d = ST_OWNED;
            ST_OWNED: begin
                // Release outranks a repeat expiring in the same cycle.
                if (owner_rel)      state_d = ST_IDLE;
                else if (delay_hit) state_d = ST_REPEAT;
            end
            ST_REPEAT: if (owner_rel) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        move_d  = MOVE_NONE;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick != MOVE_NONE) begin
                    move_d  = pick;
                    owner_d = pick;
                end
            end
            ST_OWNED: begin
                if (owner_rel) begin
                    owner_d = MOVE_NONE;
                    cnt_d   = '0;
                end else if (delay_hit) begin
                    move_d = owner_q;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_REPEAT: begin
                if (owner_rel) begin
                    owner_d = MOVE_NONE;
                    cnt_d   = '0;
                end else if (period_hit) begin
                    move_d = owner_q;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                owner_d = MOVE_NONE;
                cnt_d   = '0;
            end
        endcase
    end

    assign move = move_q;

endmodule

// File: tb/tb_move_input.sv
// tb_move_input: self-checking bench for move_input. Each segment fills a
// per-cycle table of raw button levels, derives the expected move per cycle
// from a behavioural model, then replays the table and compares every cycle.
module tb_move_input;

    localparam int D    = 4;
    localparam int R    = 20;
    localparam int P    = 8;
    localparam int NB   = 5;
    localparam int MAXN = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn = '0;
    logic [2:0]    move;

    always #5 clk = ~clk;

    move_input #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (R),
        .REPEAT_PERIOD   (P)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_up    (btn[0]),
        .btn_down  (btn[1]),
        .btn_left  (btn[2]),
        .btn_right (btn[3]),
        .btn_reset (btn[4]),
        .move      (move)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit raw [NB][MAXN];
    int exp_mv [MAXN];
    int obs_cyc[$];
    int obs_code[$];

    task automatic check(input string tag, input logic [31:0] obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_raw();
        for (int b = 0; b < NB; b++)
            for (int n = 0; n < MAXN; n++)
                raw[b][n] = 1'b0;
    endtask

    task automatic set_hold(input int b, input int from, input int len);
        for (int i = from; i < from + len; i++)
            if (i < MAXN) raw[b][i] = 1'b1;
    endtask

    // Model: debounced level per cycle from the raw table, then an owner /
    // time-since-last-pulse view of arbitration and auto-repeat.
    task automatic build_expected(input int len);
        bit dl [NB][MAXN];
        bit held [NB];
        bit press [NB];
        int owner, last, reps, gap, pk, run;
        bit lv, s;
        for (int b = 0; b < NB; b++) begin
            lv = 1'b0;
            run = 0;
            for (int n = 0; n < len; n++) begin
                s = (n >= 2) ? raw[b][n-2] : 1'b0;
                if (s != lv) begin
                    run++;
                    if (run == D) begin
                        lv = s;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
                dl[b][n] = lv;
            end
        end
        owner = -1;
        last  = 0;
        reps  = 0;
        for (int e = 0; e < len; e++) begin
            exp_mv[e] = 0;
            for (int b = 0; b < NB; b++) begin
                held[b]  = (e >= 2) ? dl[b][e-2] : 1'b0;
                press[b] = held[b] && !((e >= 3) ? dl[b][e-3] : 1'b0);
            end
            if (owner < 0) begin
                pk = -1;
                if (press[4]) pk = 4;
                for (int b = 0; b < 4; b++)
                    if (press[b] && pk < 0) pk = b;
                if (pk >= 0) begin
                    exp_mv[e] = pk + 1;
                    owner = pk;
                    last  = e;
                    reps  = 0;
                end
            end else if (!held[owner]) begin
                owner = -1;
            end else if (owner < 4 && R != 0) begin
                gap = (reps == 0) ? R + 1 : P + 1;
                if (e - last == gap) begin
                    exp_mv[e] = owner + 1;
                    last = e;
                    reps++;
                end
            end
        end
    endtask

    task automatic run_seg(input string name, input int len, input int rst_cyc);
        obs_cyc.delete();
        obs_code.delete();
        build_expected(len);
        rst_n = 1'b0;
        for (int b = 0; b < NB; b++) btn[b] = raw[b][0];
        repeat (3) @(negedge clk);
        check({name, ":rst"}, move, 0);
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            rst_n = 1'b1;
            for (int b = 0; b < NB; b++) btn[b] = raw[b][n];
            @(posedge clk);
            #1;
            check($sformatf("%s:move@%0d", name, n), move, exp_mv[n]);
            if (move != 3'd0) begin
                obs_cyc.push_back(n);
                obs_code.push_back(int'(move));
            end
            if (n == rst_cyc) begin
                #2 rst_n = 1'b0;
                #1 check({name, ":rst_async"}, move, 0);
                break;
            end
        end
    endtask

    initial begin
        // Single UP press.
        clear_raw();
        set_hold(0, 10, 12);
        run_seg("up", 60, -1);
        check("up:npulse", obs_cyc.size(), 1);
        if (obs_cyc.size() > 0) check("up:cycle", obs_cyc[0], 17);

        // Short LEFT glitch and bounce.
        clear_raw();
        set_hold(2, 10, 3);
        set_hold(2, 14, 2);
        run_seg("glitch", 50, -1);
        check("glitch:npulse", obs_cyc.size(), 0);

        // Held RIGHT auto-repeat.
        clear_raw();
        set_hold(3, 10, 60);
        run_seg("right", 110, -1);
        check("right:npulse", obs_cyc.size(), 6);
        if (obs_cyc.size() >= 3) begin
            check("right:t0", obs_cyc[0], 17);
            check("right:t1", obs_cyc[1], 38);
            check("right:t2", obs_cyc[2], 47);
            check("right:code", obs_code[0], 4);
        end

        // DOWN and RESET together, then DOWN re-pressed.
        clear_raw();
        set_hold(1, 10, 60);
        set_hold(4, 10, 30);
        set_hold(1, 90, 10);
        run_seg("down_reset", 140, -1);
        check("down_reset:npulse", obs_cyc.size(), 2);
        if (obs_cyc.size() == 2) begin
            check("down_reset:code0", obs_code[0], 5);
            check("down_reset:code1", obs_code[1], 2);
            check("down_reset:t1", obs_cyc[1], 97);
        end

        // LEFT pressed under an UP owner, still held after UP releases.
        clear_raw();
        set_hold(0, 10, 50);
        set_hold(2, 20, 60);
        run_seg("up_left", 130, -1);
        check("up_left:npulse", obs_cyc.size(), 5);
        foreach (obs_code[i]) check($sformatf("up_left:code%0d", i), obs_code[i], 1);

        // Reset during a held repeat, then button held through reset release.
        clear_raw();
        set_hold(3, 10, 100);
        run_seg("rst_hold", 120, 38);
        check("rst_hold:npulse", obs_cyc.size(), 2);
        clear_raw();
        set_hold(3, 0, 12);
        run_seg("rst_rel", 40, -1);
        check("rst_rel:npulse", obs_cyc.size(), 1);
        if (obs_cyc.size() > 0) check("rst_rel:cycle", obs_cyc[0], 7);

        // Random press/hold/glitch patterns on all buttons.
        for (int k = 0; k < 4; k++) begin
            int t;
            clear_raw();
            for (int b = 0; b < NB; b++) begin
                t = int'($urandom_range(0, 30));
                while (t < 270) begin
                    int hl;
                    hl = int'($urandom_range(1, 45));
                    set_hold(b, t, hl);
                    t += hl + int'($urandom_range(1, 40));
                end
            end
            run_seg($sformatf("rand%0d", k), 300, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
